// File: rtl/free_list.sv
// Physical-register free list: a circular buffer of free preg indices handed out at
// dispatch, refilled at retirement, and rewound to the retirement point on a squash.
module free_list #(
    parameter int unsigned NUM_PHYS_REGS = 64,
    parameter int unsigned NUM_ARCH_REGS = 32,
    localparam int unsigned PR_W = $clog2(NUM_PHYS_REGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            alloc_req,
    output logic            alloc_valid,
    output logic [PR_W-1:0] alloc_pr,
    input  logic            retire_enable,
    input  logic [PR_W-1:0] retire_old_pr,
    input  logic            squash,
    output logic [PR_W-1:0] free_count
);

    localparam int unsigned DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PR_W-1:0]  entries [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] retire_head;
    logic [CNT_W-1:0] count;

    logic             alloc_ok;
    logic             retire_ok;
    logic [PTR_W-1:0] head_inc;
    logic [PTR_W-1:0] tail_inc;
    logic [PTR_W-1:0] retire_head_inc;
    logic [CNT_W-1:0] count_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(p + PTR_W'(1));
    endfunction

    // Outputs come straight from registered state; a freed preg is never bypassed.
    assign alloc_valid = (count != '0);
    assign alloc_pr    = entries[head];
    assign free_count  = PR_W'(count);

    // Event qualification and next-count arithmetic.
    always_comb begin
        alloc_ok        = alloc_req && alloc_valid && !squash;
        retire_ok       = retire_enable && (count != CNT_W'(DEPTH));
        head_inc        = ptr_inc(head);
        tail_inc        = ptr_inc(tail);
        retire_head_inc = ptr_inc(retire_head);
        count_nxt       = count;
        if (squash) begin
            count_nxt = CNT_W'(DEPTH);
        end else if (alloc_ok && !retire_ok) begin
            count_nxt = count - CNT_W'(1);
        end else if (retire_ok && !alloc_ok) begin
            count_nxt = count + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= PR_W'(NUM_ARCH_REGS + i);
            end
            head        <= '0;
            tail        <= '0;
            retire_head <= '0;
            count       <= CNT_W'(DEPTH);
        end else begin
            if (retire_ok) begin
                entries[tail] <= retire_old_pr;
                tail          <= tail_inc;
                retire_head   <= retire_head_inc;
            end
            // Squash rewinds head to the oldest unretired allocation, including a same-cycle retire.
            if (squash) begin
                head <= retire_ok ? retire_head_inc : retire_head;
            end else if (alloc_ok) begin
                head <= head_inc;
            end
            count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed scenarios plus random traffic against a queue-based
// model of free pregs and in-flight (allocated, unretired) pregs.
module tb_free_list;

    localparam int unsigned PR_W = 6;

    logic            clock;
    logic            reset;
    logic            alloc_req;
    logic            alloc_valid;
    logic [PR_W-1:0] alloc_pr;
    logic            retire_enable;
    logic [PR_W-1:0] retire_old_pr;
    logic            squash;
    logic [PR_W-1:0] free_count;

    int unsigned total;
    int unsigned bad;

    // Model: free pregs in allocation order, and in-flight pregs oldest first.
    int unsigned free_q[$];
    int unsigned flight_q[$];

    free_list dut (
        .clock        (clock),
        .reset        (reset),
        .alloc_req    (alloc_req),
        .alloc_valid  (alloc_valid),
        .alloc_pr     (alloc_pr),
        .retire_enable(retire_enable),
        .retire_old_pr(retire_old_pr),
        .squash       (squash),
        .free_count   (free_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        free_q.delete();
        flight_q.delete();
        for (int unsigned i = 0; i < 32; i++) free_q.push_back(32 + i);
    endtask

    task automatic model_step(input bit rst, input bit a, input bit r, input int unsigned rpr,
                              input bit s);
        int unsigned tmp[$];
        bit          do_alloc;
        if (rst) begin
            model_reset();
            return;
        end
        do_alloc = a && (free_q.size() != 0) && !s;
        // A retire frees the oldest in-flight preg's old mapping; dropped when nothing is in flight.
        if (r && (flight_q.size() != 0)) begin
            void'(flight_q.pop_front());
            free_q.push_back(rpr);
        end
        if (s) begin
            tmp      = flight_q;
            flight_q.delete();
            free_q   = {tmp, free_q};
        end else if (do_alloc) begin
            flight_q.push_back(free_q[0]);
            void'(free_q.pop_front());
        end
    endtask

    task automatic check_outputs(input string tag);
        int unsigned exp_pr;
        check({tag, ".valid"}, 32'(alloc_valid), 32'(free_q.size() != 0));
        check({tag, ".count"}, 32'(free_count), free_q.size());
        if (free_q.size() != 0) begin
            exp_pr = free_q[0];
            check({tag, ".pr"}, 32'(alloc_pr), exp_pr);
        end
    endtask

    // One clock: drive, advance model, sample #1 after the edge.
    task automatic cycle(input bit rst, input bit a, input bit r, input int unsigned rpr,
                         input bit s, input string tag);
        reset         = rst;
        alloc_req     = a;
        retire_enable = r;
        retire_old_pr = PR_W'(rpr);
        squash        = s;
        @(posedge clock);
        model_step(rst, a, r, rpr, s);
        #1;
        reset = 1'b0; alloc_req = 1'b0; retire_enable = 1'b0; squash = 1'b0;
        check_outputs(tag);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0; alloc_req = 1'b0; retire_enable = 1'b0; squash = 1'b0;
        retire_old_pr = '0;
        model_reset();
        @(negedge clock);

        // Post-reset state.
        cycle(1, 0, 0, 0, 0, "reset");
        check("reset.pr_const", 32'(alloc_pr), 32);
        check("reset.cnt_const", 32'(free_count), 32);
        check("reset.valid_const", 32'(alloc_valid), 1);

        // Sequential allocation.
        for (int i = 0; i < 3; i++) begin
            check("seq.pr_const", 32'(alloc_pr), 32'(32 + i));
            cycle(0, 1, 0, 0, 0, "seq");
        end
        check("seq.pr_after", 32'(alloc_pr), 35);
        check("seq.cnt_after", 32'(free_count), 29);

        // Simultaneous alloc and retire: count unchanged.
        cycle(0, 1, 1, 5, 0, "simul");
        check("simul.cnt_const", 32'(free_count), 29);
        check("simul.pr_const", 32'(alloc_pr), 36);

        // Empty, extra request ignored, then refill without bypass.
        cycle(1, 0, 0, 0, 0, "empty.rst");
        for (int i = 0; i < 32; i++) cycle(0, 1, 0, 0, 0, "empty.alloc");
        check("empty.valid_const", 32'(alloc_valid), 0);
        check("empty.cnt_const", 32'(free_count), 0);
        cycle(0, 1, 0, 0, 0, "empty.extra");
        check("empty.extra_cnt", 32'(free_count), 0);
        cycle(0, 1, 1, 7, 0, "refill");
        check("refill.valid_const", 32'(alloc_valid), 1);
        check("refill.pr_const", 32'(alloc_pr), 7);
        check("refill.cnt_const", 32'(free_count), 1);

        // Squash rewinds to the retirement point.
        cycle(1, 0, 0, 0, 0, "sq.rst");
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0, "sq.alloc");
        cycle(0, 0, 1, 3, 0, "sq.retire");
        cycle(0, 1, 0, 0, 1, "sq.squash");
        check("sq.pr_const", 32'(alloc_pr), 33);
        check("sq.cnt_const", 32'(free_count), 32);
        for (int i = 0; i < 32; i++) begin
            check("sq.seq_const", 32'(alloc_pr), (i < 31) ? 32'(33 + i) : 32'd3);
            cycle(0, 1, 0, 0, 0, "sq.drain");
        end

        // Reset mid-operation with every other input active.
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0, 0, "mid.alloc");
        cycle(1, 0, 0, 0, 0, "mid.rst0");
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0, 0, "mid.alloc2");
        cycle(0, 0, 1, 9, 0, "mid.ret");
        cycle(0, 0, 1, 11, 0, "mid.ret");
        cycle(1, 1, 1, 13, 1, "mid.rst");
        check("mid.pr_const", 32'(alloc_pr), 32);
        check("mid.cnt_const", 32'(free_count), 32);
        check("mid.valid_const", 32'(alloc_valid), 1);

        // Illegal retire at full is dropped.
        cycle(0, 0, 1, 17, 0, "full.retire");
        check("full.cnt_const", 32'(free_count), 32);

        // Random traffic; retires only when something is in flight, except rare illegal ones at full.
        for (int n = 0; n < 4000; n++) begin
            bit          rst;
            bit          a;
            bit          r;
            bit          s;
            int unsigned rpr;
            rst = ($urandom_range(0, 299) == 0);
            s   = ($urandom_range(0, 39) == 0);
            a   = ($urandom_range(0, 1) == 1);
            r   = (flight_q.size() != 0) ? ($urandom_range(0, 2) == 0)
                                         : ($urandom_range(0, 19) == 0);
            rpr = $urandom_range(1, 63);
            cycle(rst, a, r, rpr, s, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL take parameter NUM_PHYS_REGS, default 64: total physical registers.
REQ-002 SHALL take parameter NUM_ARCH_REGS, default 32: architectural registers, permanently mapped at reset.
REQ-003 SHALL define DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS (32) as the internal circular-buffer size.
REQ-004 SHALL have one clock and a synchronous, active-high reset; the ports are named clock and reset.
REQ-005 SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-006 SHALL have port reset, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port alloc_req, input, 1 bit: dispatch consumes the head preg this cycle.
REQ-008 SHALL have port alloc_valid, output, 1 bit: alloc_pr is a valid free preg.
REQ-009 SHALL have port alloc_pr, output, `PHYS_REG_IDX_SZ+1 bits: head preg index; drives the map table new_dest_pr.
REQ-010 SHALL have port retire_enable, input, 1 bit: a retiring instruction that allocated a preg frees its old mapping.
REQ-011 SHALL have port retire_old_pr, input, `PHYS_REG_IDX_SZ+1 bits: preg freed at retirement (map table old_dest_pr captured at dispatch).
REQ-012 SHALL have port squash, input, 1 bit: full pipeline flush; all unretired allocations are returned.
REQ-013 SHALL have port free_count, output, `PHYS_REG_IDX_SZ+1 bits: number of free pregs.

Function
REQ-014 SHALL store preg indices in a DEPTH-entry circular buffer with registered head, tail, retire_head pointers (mod DEPTH) and a count register.
REQ-015 SHALL drive alloc_valid = (count != 0), alloc_pr = entry[head], free_count = count, all combinational from registers.
REQ-016 SHALL, at posedge with alloc_req=1 and alloc_valid=1 and squash=0, advance head by 1 with wrap and decrement count.
REQ-017 SHALL ignore alloc_req when alloc_valid=0, leaving head and count unchanged.
REQ-018 SHALL, at posedge with retire_enable=1, write retire_old_pr to entry[tail], then advance tail and retire_head by 1 with wrap and increment count.
REQ-019 SHALL leave count unchanged when an allocate and a retire occur in the same cycle; head and tail both advance.
REQ-020 SHALL NOT bypass: a preg freed in cycle N is allocatable no earlier than cycle N+1, including when the list is empty.
REQ-021 SHALL drop retire_enable when count == DEPTH; this is illegal stimulus and leaves no state change.
REQ-022 SHALL NOT receive retire_enable for instructions with destination areg 0; preg 0 is never freed or allocated.
REQ-023 SHALL, at posedge with squash=1, set head = retire_head after applying a same-cycle retire, set count = DEPTH, and ignore alloc_req.
REQ-024 SHALL, on a same-cycle squash and retire, still write entry[tail] and advance tail and retire_head.
REQ-025 SHALL hold all state when no input event occurs.

Reset
REQ-026 SHALL, on reset=1 at posedge, set entry[i] = NUM_ARCH_REGS+i for i in 0..DEPTH-1, head = tail = retire_head = 0, and count = DEPTH.
REQ-027 SHALL give reset priority over squash, alloc_req and retire_enable.
REQ-028 SHALL, in the cycle after reset, present alloc_valid=1, alloc_pr=32 and free_count=32.

Verification
REQ-029 SHALL cover post-reset: reset one cycle -> alloc_pr=32, alloc_valid=1, free_count=32.
REQ-030 SHALL cover sequential allocation: alloc_req for 3 cycles -> alloc_pr observed 32, 33, 34; then alloc_pr=35, free_count=29.
REQ-031 SHALL cover simultaneous events: alloc_req plus retire_enable with retire_old_pr=5 -> free_count unchanged, head advances, entry[tail] becomes 5.
REQ-032 SHALL cover empty and refill: 32 allocations -> alloc_valid=0, free_count=0; extra alloc_req changes nothing; retire pr 7 -> next cycle alloc_valid=1, alloc_pr=7.
REQ-033 SHALL cover squash: allocate 32..35, retire old pr 3, then squash -> alloc_pr=33, free_count=32; further allocations yield 34..63, then 3.
REQ-034 SHALL cover reset mid-operation: reset after 10 allocations and 2 retires -> next cycle matches the REQ-028 state exactly.
